// File: rtl/spi_xform_slave.sv
// SPI mode-0 slave: receives a DATA_W-bit word MSB-first, then shifts out a
// transformed copy of it; repeats word by word while ss stays low.
`timescale 1ns/1ps

module spi_xform_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sck,
  input  logic              i_ss,
  input  logic              i_mosi,
  input  logic [1:0]        i_mode,
  output logic              o_miso,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RX   = 2'd1;
  localparam logic [1:0] S_TX   = 2'd2;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-2:0]      r_shreg;
  logic [DATA_W-1:0]      r_tx_reg;
  logic                   r_miso;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;

  logic                   w_sck_s;
  logic                   w_ss_s;
  logic                   w_mosi_s;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_last;
  logic [DATA_W-1:0]      w_word;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] xform(input logic [1:0] m,
                                              input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (m)
      2'b00:   r = bit_rev(d);
      2'b01:   r = d;
      2'b10:   r = ~d;
      default: r = ~bit_rev(d);
    endcase
    return r;
  endfunction

  // ss synchroniser resets to the deselected level so the slave does not
  // briefly leave IDLE while the first real ss sample ripples through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sck_d     <= w_sck_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_last     = (r_bit_cnt == LAST_BIT);
  assign w_word     = {r_shreg, w_mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx_reg   <= '0;
      r_miso     <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_ss_s) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
        r_tx_reg  <= '0;
        r_miso    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_RX;
            r_bit_cnt <= '0;
            r_miso    <= 1'b1;
          end
          S_RX: begin
            // A fall here follows the last TX rise; return miso to idle.
            if (w_sck_fall) begin
              r_miso <= 1'b1;
            end
            if (w_sck_rise) begin
              r_shreg <= w_word[DATA_W-2:0];
              if (w_last) begin
                r_rx_data  <= w_word;
                r_rx_valid <= 1'b1;
                r_tx_reg   <= xform(i_mode, w_word);
                r_bit_cnt  <= '0;
                r_state    <= S_TX;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          S_TX: begin
            if (w_sck_fall) begin
              r_miso   <= r_tx_reg[DATA_W-1];
              r_tx_reg <= {r_tx_reg[DATA_W-2:0], 1'b0};
            end
            if (w_sck_rise) begin
              if (w_last) begin
                r_bit_cnt <= '0;
                r_state   <= S_RX;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_xform_slave.sv
// Bench for spi_xform_slave: an 8-bit and a 16-bit slave share sck/mosi,
// each with its own ss; received words and TX words are scoreboarded.
`timescale 1ns/1ps

module tb_spi_xform_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n8, rst_n16, sck, mosi, ss8, ss16;
  logic [1:0]  mode;
  logic        miso8, rx_valid8, busy8;
  logic [7:0]  rx_data8;
  logic        miso16, rx_valid16, busy16;
  logic [15:0] rx_data16;

  int checks = 0;
  int failures = 0;
  int valid_cnt8 = 0;
  int valid_cnt16 = 0;
  logic [15:0] exp_rx8[$];
  logic [15:0] exp_rx16[$];
  logic [15:0] exp_tx[$];
  logic [15:0] mon_e8, mon_e16;

  spi_xform_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .i_sck(sck), .i_ss(ss8), .i_mosi(mosi),
    .i_mode(mode), .o_miso(miso8), .o_rx_data(rx_data8),
    .o_rx_valid(rx_valid8), .o_busy(busy8));

  spi_xform_slave #(.DATA_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n16), .i_sck(sck), .i_ss(ss16), .i_mosi(mosi),
    .i_mode(mode), .o_miso(miso16), .o_rx_data(rx_data16),
    .o_rx_valid(rx_valid16), .o_busy(busy16));

  function automatic logic [15:0] model(input int w, input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] rev, r, mask;
    rev = '0;
    for (int i = 0; i < w; i++) rev[i] = d[w-1-i];
    case (m)
      2'b00:   r = rev;
      2'b01:   r = d;
      2'b10:   r = ~d;
      default: r = ~rev;
    endcase
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    return r & mask;
  endfunction

  always @(negedge clk) begin
    if (rx_valid8 === 1'b1) begin
      valid_cnt8++;
      checks++;
      if (exp_rx8.size() == 0) begin
        failures++;
        $display("FAIL rx_valid8_unexpected got rx_data=%h required no pulse", rx_data8);
      end else begin
        mon_e8 = exp_rx8.pop_front();
        if (rx_data8 !== mon_e8[7:0]) begin
          failures++;
          $display("FAIL rx_data8 got %h required %h", rx_data8, mon_e8[7:0]);
        end else $display("rx8 word %h ok", rx_data8);
      end
    end
    if (rx_valid16 === 1'b1) begin
      valid_cnt16++;
      checks++;
      if (exp_rx16.size() == 0) begin
        failures++;
        $display("FAIL rx_valid16_unexpected got rx_data=%h required no pulse", rx_data16);
      end else begin
        mon_e16 = exp_rx16.pop_front();
        if (rx_data16 !== mon_e16) begin
          failures++;
          $display("FAIL rx_data16 got %h required %h", rx_data16, mon_e16);
        end else $display("rx16 word %h ok", rx_data16);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout got no finish required finish within 2ms");
    $fatal(1, "timeout");
  end

  task automatic spi_bit(input logic mo, input int h, input bit w16, output logic mi);
    mosi = mo;
    repeat (h) @(negedge clk);
    mi = w16 ? miso16 : miso8;
    sck = 1'b1;
    repeat (h) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic frame_start(input bit w16);
    if (w16) ss16 = 1'b0; else ss8 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end(input bit w16);
    if (w16) ss16 = 1'b1; else ss8 = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One RX word followed by one TX word; returns what the master read on miso.
  task automatic xfer_word(input bit w16, input logic [15:0] word, input logic [1:0] md,
                           input int h, output logic [15:0] got);
    automatic int w = w16 ? 16 : 8;
    automatic logic rx_ones = 1'b1;
    logic mi;
    logic [15:0] e;
    mode = md;
    if (w16) exp_rx16.push_back(word); else exp_rx8.push_back(word);
    exp_tx.push_back(model(w, word, md));
    for (int i = 0; i < w; i++) begin
      spi_bit(word[w-1-i], h, w16, mi);
      if (mi !== 1'b1) rx_ones = 1'b0;
    end
    checks++;
    if (rx_ones !== 1'b1) begin
      failures++;
      $display("FAIL rx_miso_idle got a non-1 miso bit required all 1 (word %h)", word);
    end
    got = '0;
    for (int i = 0; i < w; i++) begin
      spi_bit(1'($urandom_range(0, 1)), h, w16, mi);
      got = {got[14:0], mi};
    end
    e = exp_tx.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL tx_word got %h required %h (rx %h mode %0d ratio %0d)", got, e, word, md, 2*h);
    end else $display("xfer w%0d rx %h mode %0d tx %h ratio %0d ok", w, word, md, got, 2*h);
  endtask

  task automatic test_reset();
    rst_n8 = 1'b0; rst_n16 = 1'b0;
    sck = 1'b0; mosi = 1'b0; ss8 = 1'b1; ss16 = 1'b1; mode = 2'b00;
    repeat (3) @(negedge clk);
    rst_n8 = 1'b1; rst_n16 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (miso8 !== 1'b1) begin failures++; $display("FAIL reset_miso got %b required 1", miso8); end
    checks++; if (rx_data8 !== 8'h00) begin failures++; $display("FAIL reset_rx_data got %h required 00", rx_data8); end
    checks++; if (rx_valid8 !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b required 0", rx_valid8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy8); end
    checks++; if (rx_data16 !== 16'h0000) begin failures++; $display("FAIL reset_rx_data16 got %h required 0000", rx_data16); end
    $display("reset checked");
  endtask

  task automatic test_bitrev();
    logic [15:0] got;
    frame_start(0);
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL bitrev_busy got %b required 1", busy8); end
    xfer_word(0, 16'h00A1, 2'b00, 4, got);
    checks++; if (got[7:0] !== 8'h85) begin failures++; $display("FAIL bitrev_const got %h required 85", got[7:0]); end
    frame_end(0);
    checks++; if (busy8 !== 1'b0 || miso8 !== 1'b1) begin
      failures++; $display("FAIL bitrev_idle got busy=%b miso=%b required busy=0 miso=1", busy8, miso8);
    end
  endtask

  task automatic test_modes();
    logic [1:0] mds [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] exps [3] = '{8'hA1, 8'h5E, 8'h7A};
    logic [15:0] got;
    for (int k = 0; k < 3; k++) begin
      frame_start(0);
      xfer_word(0, 16'h00A1, mds[k], 4, got);
      checks++;
      if (got[7:0] !== exps[k]) begin
        failures++; $display("FAIL mode_const got %h required %h (mode %0d)", got[7:0], exps[k], mds[k]);
      end
      frame_end(0);
    end
  endtask

  task automatic test_multiword();
    logic [7:0] ws [3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] exps [3] = '{8'h80, 8'h01, 8'hFF};
    logic [15:0] got;
    int vc0;
    vc0 = valid_cnt8;
    frame_start(0);
    for (int k = 0; k < 3; k++) begin
      xfer_word(0, {8'h00, ws[k]}, 2'b00, 4, got);
      checks++;
      if (got[7:0] !== exps[k] || busy8 !== 1'b1) begin
        failures++; $display("FAIL multiword got tx=%h busy=%b required tx=%h busy=1", got[7:0], busy8, exps[k]);
      end
    end
    frame_end(0);
    checks++;
    if (valid_cnt8 - vc0 != 3 || busy8 !== 1'b0) begin
      failures++; $display("FAIL multiword_pulses got %0d busy=%b required 3 busy=0", valid_cnt8 - vc0, busy8);
    end
  endtask

  task automatic test_abort();
    logic mi;
    logic [15:0] got;
    int vc0;
    vc0 = valid_cnt8;
    frame_start(0);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), 4, 0, mi);
    ss8 = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (valid_cnt8 != vc0 || miso8 !== 1'b1 || busy8 !== 1'b0 || rx_data8 !== 8'hFF) begin
      failures++;
      $display("FAIL abort got pulses=%0d miso=%b busy=%b rx=%h required 0 1 0 ff",
               valid_cnt8 - vc0, miso8, busy8, rx_data8);
    end else $display("abort ok");
    frame_start(0);
    xfer_word(0, 16'h003C, 2'b00, 4, got);
    checks++; if (got[7:0] !== 8'h3C) begin failures++; $display("FAIL abort_clean got %h required 3c", got[7:0]); end
    frame_end(0);
  endtask

  task automatic test_reset_mid_tx();
    logic mi;
    frame_start(0);
    mode = 2'b00;
    exp_rx8.push_back(16'h005A);
    for (int i = 7; i >= 0; i--) spi_bit(1'(8'h5A >> i), 4, 0, mi);
    for (int i = 0; i < 2; i++) spi_bit(1'b0, 4, 0, mi);
    mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n8 = 1'b0;
    #1;
    checks++;
    if (miso8 !== 1'b1 || rx_data8 !== 8'h00 || rx_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_tx got miso=%b rx=%h valid=%b busy=%b required 1 00 0 0",
               miso8, rx_data8, rx_valid8, busy8);
    end else $display("reset mid tx ok");
    sck = 1'b0; ss8 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n8 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_width16();
    logic [15:0] got;
    frame_start(1);
    xfer_word(1, 16'h1234, 2'b00, 4, got);
    checks++; if (got !== 16'h2C48) begin failures++; $display("FAIL width16_const got %h required 2c48", got); end
    xfer_word(1, 16'(($urandom)), 2'($urandom_range(0, 3)), 4, got);
    frame_end(1);
  endtask

  task automatic test_oversample();
    int hs [3] = '{4, 5, 8};
    logic [15:0] got;
    int vc0;
    for (int k = 0; k < 3; k++) begin
      vc0 = valid_cnt8;
      frame_start(0);
      for (int n = 0; n < 4; n++)
        xfer_word(0, {8'h00, 8'($urandom)}, 2'($urandom_range(0, 3)), hs[k], got);
      frame_end(0);
      checks++;
      if (valid_cnt8 - vc0 != 4) begin
        failures++; $display("FAIL oversample_pulses got %0d required 4 (ratio %0d)", valid_cnt8 - vc0, 2*hs[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_modes();
    test_multiword();
    test_abort();
    test_reset_mid_tx();
    test_width16();
    test_oversample();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_rx8.size() != 0 || exp_rx16.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", exp_rx8.size(), exp_rx16.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
